fg_sweep_sequencer: RTL
=======================

Name: fg_sweep_sequencer

Overview:
- Programmable sweep controller for the function-generator datapath: frequency selector, waveform generator, amplitude selector and PWM.
- Holds a table of up to DEPTH steps. Each step is a (waveform, amplitude, frequency code, dwell) tuple.
- On start it applies each step in turn, holds it for its dwell time, then advances. It stops at the last step or loops.
- Replaces static switch settings as the source of waveSelector, amplitude selector and frequency parIn/ld/rst controls.

Parameters:
- DEPTH, 8, number of step-table entries (power of 2, 2..16).
- DWELL_W, 16, width of the per-step dwell count, in tick_in pulses.
- IDX_W, $clog2(DEPTH), width of step index/address.

Ports:
- clk  in  1  system clock (same clk feeding the frequency selector and PWM)
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  step-table write strobe
- cfg_addr  in  IDX_W  table entry to write
- cfg_data  in  8+DWELL_W  {wave[2:0], amp[1:0], freq[2:0], dwell[DWELL_W-1:0]}, MSB first
- num_steps  in  IDX_W+1  steps in sweep; sampled at start
- loop_en  in  1  1 = wrap to step 0 after last step
- start  in  1  one-cycle start request
- stop  in  1  one-cycle abort request
- tick_in  in  1  one-cycle dwell time-base strobe, synchronous to clk
- wave_sel  out  3  waveSelector for waveform generator
- amp_sel  out  2  amplitude selector code
- freq_sel  out  3  parIn for frequency selector
- apply  out  1  one-cycle pulse; drive frequency-selector ld and waveform-generator restart
- busy  out  1  high in LOAD/DWELL
- step_idx  out  IDX_W  index of the currently applied step
- done  out  1  one-cycle pulse at natural sweep end

Behaviour:
- Reset (async, immediate): state IDLE, wave_sel=0, amp_sel=0, freq_sel=0, apply=0, busy=0, done=0, step_idx=0, dwell counter=0. Table contents are not reset.
- All outputs are registered.
- Table writes:
  - cfg_we writes cfg_data to entry cfg_addr at the clock edge, in any state.
  - A write to the active entry takes effect only at its next LOAD.
- States: IDLE, LOAD, DWELL.
- IDLE:
  - start=1 with stop=0 and latched count N≥1: latch N = min(num_steps, DEPTH), step_idx=0, go to LOAD.
  - num_steps=0: start is ignored and done is not pulsed.
  - wave/amp/freq outputs hold their last applied values.
- LOAD (exactly 1 cycle):
  - Registers the table[step_idx] fields onto wave_sel/amp_sel/freq_sel.
  - apply=1 in the same cycle the new values appear.
  - Dwell counter is loaded with max(dwell,1)-1.
  - Next state is DWELL.
- DWELL:
  - tick_in with counter≠0: decrement.
  - tick_in with counter=0: end of step.
    - step_idx<N-1: step_idx+1, go to LOAD.
    - step_idx=N-1 and loop_en=1: step_idx=0, go to LOAD.
    - step_idx=N-1 and loop_en=0: go to IDLE, done=1 for one cycle.
  - loop_en is sampled at end of the last step, not at start.
- Latency:
  - start edge to first apply pulse: 1 cycle.
  - Final dwell tick to next apply pulse: 1 cycle.
  - A step of dwell D occupies 1 LOAD cycle plus D tick_in pulses.
- stop:
  - In any state, go to IDLE on the next edge. busy=0, no done, no apply. Outputs hold current values and step_idx holds.
  - stop wins over a simultaneous start or end-of-step.
- start while busy is ignored, with no restart.
- tick_in during LOAD is ignored and not counted.
- The dwell field is treated as an unsigned DWELL_W-bit value; dwell=0 behaves as 1.

Decomposition:
- Shared package fg_pkg:
  - State enum (IDLE/LOAD/DWELL).
  - Field widths WAVE_W=3, AMP_W=2, FREQ_W=3.
  - cfg_data field offsets and the step-entry struct/typedef, reused by any future CPU/UART configuration front end.
- One sub-module: fg_step_table.
  - DEPTH×(8+DWELL_W) register file: one synchronous write port, one asynchronous read port addressed by step_idx.
  - No reset on the array.
- The FSM and dwell counter live in fg_sweep_sequencer.

Test Plan:
1. Reset: assert rst mid-DWELL of step 2 → all outputs 0 and state IDLE asynchronously; after release, start replays from step 0.
2. Basic 3-step sweep, loop_en=0:
   - Table {wave 1, amp 3, freq 2, dwell 4}, {2, 1, 5, 2}, {4, 0, 7, 1}; tick_in every cycle.
   - Required: apply pulses at cycles 1, 6, 9; wave_sel 1→2→4; done at cycle 11; busy falls with done.
3. Looping:
   - Same table, loop_en=1, for 3 sweeps → step_idx sequence 0,1,2,0,1,2,0 with no gap cycle.
   - Clear loop_en during step 1 → done after step 2.
4. Boundary cases:
   - num_steps=0 with start → no apply, no done.
   - num_steps=12 (DEPTH=8) → clamped to 8 steps.
   - dwell=0 entry → held exactly 1 tick.
5. stop and start collisions:
   - stop and start together in IDLE → stays IDLE.
   - stop on the same cycle as the final tick of step 1 → IDLE, step_idx=1, outputs hold step-1 values, no apply, no done.
   - start while busy → ignored.
6. Live table write:
   - Rewrite the active entry 1 during its DWELL → outputs unchanged until a looped revisit of step 1 shows the new values.
   - tick_in pulsed during a LOAD cycle is not counted.

Source files
------------

// File: rtl/fg_pkg.sv
// Shared types and field layout for the function-generator sweep sequencer.
package fg_pkg;

   localparam int unsigned WAVE_W      = 3;
   localparam int unsigned AMP_W       = 2;
   localparam int unsigned FREQ_W      = 3;
   localparam int unsigned HDR_W       = WAVE_W + AMP_W + FREQ_W;
   localparam int unsigned DWELL_W_DEF = 16;

   // Field offsets above the dwell field in a cfg_data word {wave, amp, freq, dwell}
   localparam int unsigned FREQ_OFS    = 0;
   localparam int unsigned AMP_OFS     = FREQ_W;
   localparam int unsigned WAVE_OFS    = FREQ_W + AMP_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DWELL = 2'd2
   } fg_state_e;

   typedef struct packed {
      logic [WAVE_W-1:0] wave;
      logic [AMP_W-1:0]  amp;
      logic [FREQ_W-1:0] freq;
   } fg_step_hdr_t;

   typedef struct packed {
      fg_step_hdr_t           hdr;
      logic [DWELL_W_DEF-1:0] dwell;
   } fg_step_t;

endpackage

// File: rtl/fg_step_table.sv
// Step table: one synchronous write port, one asynchronous read port, no reset.
module fg_step_table
   import fg_pkg::*;
#(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned DATA_W = 24,
   parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [IDX_W-1:0]  i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Configuration write, allowed in any sequencer state
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fg_sweep_sequencer.sv
// Sweep sequencer: steps through the table, holding each entry for its dwell in ticks.
module fg_sweep_sequencer
   import fg_pkg::*;
#(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned DWELL_W = 16,
   parameter int unsigned IDX_W   = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_we,
   input  logic [IDX_W-1:0]         cfg_addr,
   input  logic [HDR_W+DWELL_W-1:0] cfg_data,
   input  logic [IDX_W:0]           num_steps,
   input  logic                     loop_en,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     tick_in,
   output logic [WAVE_W-1:0]        wave_sel,
   output logic [AMP_W-1:0]         amp_sel,
   output logic [FREQ_W-1:0]        freq_sel,
   output logic                     apply,
   output logic                     busy,
   output logic [IDX_W-1:0]         step_idx,
   output logic                     done
);

   localparam int unsigned CFG_W = HDR_W + DWELL_W;
   localparam int unsigned CNT_W = IDX_W + 1;

   fg_state_e          r_state, w_nxt_state;
   logic [IDX_W-1:0]   r_idx, w_nxt_idx;
   logic [CNT_W-1:0]   r_n, w_nxt_n, w_clamp_n;
   logic [DWELL_W-1:0] r_cnt, w_nxt_cnt, w_load_cnt, w_dwell;
   logic [CFG_W-1:0]   w_entry;
   fg_step_hdr_t       r_hdr, w_hdr;
   logic               w_load, w_done, w_last;
   logic               r_apply, r_busy, r_done;

   // Table is read at the index being loaded so the fields land with the apply pulse
   fg_step_table #(
      .DEPTH  (DEPTH),
      .DATA_W (CFG_W),
      .IDX_W  (IDX_W)
   ) u_table (
      .clk     (clk),
      .i_we    (cfg_we),
      .i_waddr (cfg_addr),
      .i_wdata (cfg_data),
      .i_raddr (w_nxt_idx),
      .o_rdata (w_entry)
   );

   assign w_clamp_n = (num_steps > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : num_steps;
   assign w_last    = (CNT_W'(r_idx) == (r_n - CNT_W'(1)));
   assign w_dwell   = w_entry[DWELL_W-1:0];
   assign w_load_cnt = (w_dwell == '0) ? '0 : (w_dwell - DWELL_W'(1));

   // Unpack the selector fields of the entry being loaded
   always_comb begin
      w_hdr      = '0;
      w_hdr.wave = w_entry[DWELL_W + WAVE_OFS +: WAVE_W];
      w_hdr.amp  = w_entry[DWELL_W + AMP_OFS  +: AMP_W];
      w_hdr.freq = w_entry[DWELL_W + FREQ_OFS +: FREQ_W];
   end

   // Next-state, step advance and dwell countdown; stop overrides everything
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_idx   = r_idx;
      w_nxt_n     = r_n;
      w_nxt_cnt   = r_cnt;
      w_load      = 1'b0;
      w_done      = 1'b0;
      if (stop) begin
         w_nxt_state = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start && (num_steps != '0)) begin
                  w_nxt_n     = w_clamp_n;
                  w_nxt_idx   = '0;
                  w_nxt_state = ST_LOAD;
                  w_load      = 1'b1;
               end
            end
            ST_LOAD: begin
               w_nxt_state = ST_DWELL;
            end
            ST_DWELL: begin
               if (tick_in) begin
                  if (r_cnt != '0) begin
                     w_nxt_cnt = r_cnt - DWELL_W'(1);
                  end else if (!w_last) begin
                     w_nxt_idx   = r_idx + IDX_W'(1);
                     w_nxt_state = ST_LOAD;
                     w_load      = 1'b1;
                  end else if (loop_en) begin
                     w_nxt_idx   = '0;
                     w_nxt_state = ST_LOAD;
                     w_load      = 1'b1;
                  end else begin
                     w_nxt_state = ST_IDLE;
                     w_done      = 1'b1;
                  end
               end
            end
            default: begin
               w_nxt_state = ST_IDLE;
            end
         endcase
      end
   end

   // State, step index, latched step count and dwell counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_n     <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nxt_state;
         r_idx   <= w_nxt_idx;
         r_n     <= w_nxt_n;
         r_cnt   <= w_load ? w_load_cnt : w_nxt_cnt;
      end
   end

   // Registered outputs; selector fields only change on a load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hdr   <= '0;
         r_apply <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         if (w_load) begin
            r_hdr <= w_hdr;
         end
         r_apply <= w_load;
         r_done  <= w_done;
         r_busy  <= (w_nxt_state != ST_IDLE);
      end
   end

   assign wave_sel = r_hdr.wave;
   assign amp_sel  = r_hdr.amp;
   assign freq_sel = r_hdr.freq;
   assign apply    = r_apply;
   assign busy     = r_busy;
   assign done     = r_done;
   assign step_idx = r_idx;

endmodule
